keypad_entry_ctrl: RTL and testbench

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

---
 rtl/keypad_entry_ctrl.sv | 134 +++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: collects up to four BCD digits, edits them, and commits the number
// over a valid/ready handshake; auto-clears an abandoned entry after TIMEOUT idle cycles.
module keypad_entry_ctrl #(
  parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  key_code,
  input  logic        key_valid,
  output logic [15:0] entry,
  output logic [2:0]  digit_count,
  output logic [15:0] value,
  output logic        value_valid,
  input  logic        value_ready,
  output logic        err,
  output logic        timeout
);

  typedef enum logic [1:0] {StIdle, StEntry, StHold} state_e;

  localparam logic [3:0] KeyBksp  = 4'd10;
  localparam logic [3:0] KeyClear = 4'd11;
  localparam logic [3:0] KeyEnter = 4'd12;

  state_e      state_q, state_d;
  logic [15:0] entry_q, entry_d;
  logic [2:0]  count_q, count_d;
  logic [15:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        timeout_q, timeout_d;
  logic [23:0] idle_cnt_q, idle_cnt_d;
  logic        is_digit;

  assign is_digit = (key_code <= 4'd9);

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    count_d    = count_q;
    value_d    = value_q;
    valid_d    = valid_q;
    err_d      = 1'b0;
    timeout_d  = 1'b0;
    // Counter defaults to zero so it clears on every key and whenever we are not in entry.
    idle_cnt_d = '0;

    unique case (state_q)
      StIdle: begin
        if (key_valid) begin
          if (is_digit) begin
            entry_d = {12'h000, key_code};
            count_d = 3'd1;
            state_d = StEntry;
          end else if (key_code == KeyBksp || key_code == KeyEnter) begin
            err_d = 1'b1;
          end
        end
      end
      StEntry: begin
        if (key_valid) begin
          if (is_digit) begin
            if (count_q < 3'd4) begin
              entry_d = {entry_q[11:0], key_code};
              count_d = count_q + 3'd1;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_code == KeyBksp) begin
            entry_d = {4'h0, entry_q[15:4]};
            count_d = count_q - 3'd1;
            if (count_q == 3'd1) state_d = StIdle;
          end else if (key_code == KeyClear) begin
            entry_d = '0;
            count_d = '0;
            state_d = StIdle;
          end else if (key_code == KeyEnter) begin
            value_d = entry_q;
            valid_d = 1'b1;
            entry_d = '0;
            count_d = '0;
            state_d = StHold;
          end
        end else if (idle_cnt_q == TIMEOUT - 24'd1) begin
          entry_d   = '0;
          count_d   = '0;
          state_d   = StIdle;
          timeout_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 24'd1;
        end
      end
      StHold: begin
        if (value_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
        // Keys are dropped while a value is pending, including on the handshake cycle.
        if (key_valid && key_code <= KeyEnter) err_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      entry_q    <= '0;
      count_q    <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      count_q    <= count_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign entry       = entry_q;
  assign digit_count = count_q;
  assign value       = value_q;
  assign value_valid = valid_q;
  assign err         = err_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl: stimulus queues expected err/timeout/value events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_keypad_entry_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  key_code = '0;
  logic        key_valid = 1'b0;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic [15:0] value;
  logic        value_valid;
  logic        value_ready = 1'b0;
  logic        err;
  logic        timeout;

  keypad_entry_ctrl #(.TIMEOUT(24'd16)) dut (
    .clock       (clock),
    .reset       (reset),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .entry       (entry),
    .digit_count (digit_count),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .err         (err),
    .timeout     (timeout)
  );

  always #5 clock = ~clock;

  localparam int EvErr = 1;
  localparam int EvTmo = 2;
  localparam int EvVal = 3;

  typedef struct {
    int          kind;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int kind, input logic [15:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind, input logic [15:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d with nothing expected at %0t", kind, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == EvVal) check("event_value", {16'h0, data}, {16'h0, e.data});
    end
  endtask

  // Monitor: samples away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      if (err && timeout) begin
        total++;
        bad++;
        $display("FAIL err_and_timeout: got both high expected at most one at %0t", $time);
      end
      if (value_valid && value_ready) pop_check(EvVal, value);
      if (err) pop_check(EvErr, 16'h0);
      if (timeout) pop_check(EvTmo, 16'h0);
    end
  end

  task automatic press(input logic [3:0] code);
    @(posedge clock);
    #2;
    key_code  = code;
    key_valid = 1'b1;
    @(posedge clock);
    #2;
    key_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    check("rst_entry", {16'h0, entry}, 32'h0);
    check("rst_count", {29'h0, digit_count}, 32'h0);
    check("rst_valid", {31'h0, value_valid}, 32'h0);
    check("rst_err_tmo", {30'h0, err, timeout}, 32'h0);
    @(posedge clock);
    #2;
    reset = 1'b1;

    // Ignored code and CLEAR in idle raise nothing; ENTER in idle errs
    press(4'd13);
    press(4'd11);
    push(EvErr, 16'h0);
    press(4'd12);
    check("idle_enter_count", {29'h0, digit_count}, 32'h0);

    // 1,2,3,ENTER then ready two cycles later
    press(4'd1);
    press(4'd2);
    press(4'd3);
    check("e123_entry", {16'h0, entry}, 32'h0123);
    check("e123_count", {29'h0, digit_count}, 32'd3);
    press(4'd12);
    check("hold_valid0", {31'h0, value_valid}, 32'h1);
    check("hold_value", {16'h0, value}, 32'h0123);
    check("hold_entry", {16'h0, entry}, 32'h0);
    @(posedge clock);
    #2;
    check("hold_valid1", {31'h0, value_valid}, 32'h1);
    push(EvVal, 16'h0123);
    value_ready = 1'b1;
    @(posedge clock);
    #2;
    value_ready = 1'b0;
    check("hs_valid", {31'h0, value_valid}, 32'h0);
    check("hs_value_kept", {16'h0, value}, 32'h0123);
    push(EvErr, 16'h0);
    press(4'd10);  // backspace errs only if back in idle
    check("hs_idle_count", {29'h0, digit_count}, 32'h0);

    // 9,8,7,6,5 overflow
    press(4'd9);
    press(4'd8);
    press(4'd7);
    press(4'd6);
    push(EvErr, 16'h0);
    press(4'd5);
    check("ovf_entry", {16'h0, entry}, 32'h9876);
    check("ovf_count", {29'h0, digit_count}, 32'd4);
    press(4'd11);
    check("clr_entry", {16'h0, entry}, 32'h0);

    // 4,5,BS,BS,BS
    press(4'd4);
    press(4'd5);
    press(4'd10);
    check("bs1_entry", {16'h0, entry}, 32'h0004);
    check("bs1_count", {29'h0, digit_count}, 32'd1);
    press(4'd10);
    check("bs2_entry", {16'h0, entry}, 32'h0);
    check("bs2_count", {29'h0, digit_count}, 32'd0);
    push(EvErr, 16'h0);
    press(4'd10);

    // Timeout 16 cycles after key edge
    push(EvTmo, 16'h0);
    press(4'd7);
    for (int i = 1; i <= 15; i++) begin
      @(posedge clock);
      #1;
      check("tmo_early", {31'h0, timeout}, 32'h0);
    end
    @(posedge clock);
    #1;
    check("tmo_pulse", {31'h0, timeout}, 32'h1);
    check("tmo_entry", {16'h0, entry}, 32'h0);
    check("tmo_count", {29'h0, digit_count}, 32'h0);
    @(posedge clock);
    #1;
    check("tmo_single", {31'h0, timeout}, 32'h0);

    // Key together with handshake in HOLD
    press(4'd1);
    press(4'd12);
    @(posedge clock);
    #2;
    push(EvVal, 16'h0001);
    push(EvErr, 16'h0);
    key_code    = 4'd3;
    key_valid   = 1'b1;
    value_ready = 1'b1;
    @(posedge clock);
    #2;
    key_valid   = 1'b0;
    value_ready = 1'b0;
    check("hk_valid", {31'h0, value_valid}, 32'h0);
    check("hk_err", {31'h0, err}, 32'h1);
    check("hk_entry", {16'h0, entry}, 32'h0);

    // Asynchronous reset mid-entry
    press(4'd2);
    press(4'd3);
    check("pre_rst_count", {29'h0, digit_count}, 32'd2);
    #4;
    reset = 1'b0;
    #1;
    check("arst_entry", {16'h0, entry}, 32'h0);
    check("arst_count", {29'h0, digit_count}, 32'h0);
    check("arst_value", {16'h0, value}, 32'h0);
    check("arst_flags", {29'h0, value_valid, err, timeout}, 32'h0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    press(4'd5);
    check("post_rst_entry", {16'h0, entry}, 32'h0005);
    press(4'd11);

    repeat (3) @(posedge clock);
    #2;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
